// File: rtl/detonator_pkg.sv
// ============================================================================
// detonator_pkg : shared state encoding and widths for the detonator sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package detonator_pkg;

  localparam int REM_W = 8;
  localparam int ERR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SAFE  = 2'd2,
    ST_BOOM  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rt_tick.sv
// ============================================================================
// rt_tick : one-cycle tick on each rising edge of a blinker square wave,
//           masked for the first cycle after the enable rises.  Rev 1.0
// ============================================================================
`default_nettype none

module rt_tick (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_rt,
  output logic o_tick
);

  logic r_en_q;
  logic r_rt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q <= 1'b0;
      r_rt_q <= 1'b0;
    end else begin
      r_en_q <= i_en;
      r_rt_q <= i_rt;
    end
  end

  // r_en_q gates out a stale high level of i_rt seen right after enable
  assign o_tick = i_en & r_en_q & i_rt & ~r_rt_q;

endmodule

`default_nettype wire

// File: rtl/detonator_seq.sv
// ============================================================================
// detonator_seq : countdown sequencer (idle/armed/safe/boom) timed by the
//                 red_led blinker toggle output.  Rev 1.0
// ============================================================================
`default_nettype none

module detonator_seq
  import detonator_pkg::*;
#(
  parameter int unsigned ARM_SECS    = 30,
  parameter int unsigned ERR_PENALTY = 5,
  parameter int unsigned MAX_ERR     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             disarm,
  input  logic             err,
  input  logic             blink_rt,
  output logic             blink_en,
  output logic             led,
  output logic [1:0]       state,
  output logic [REM_W-1:0] remaining,
  output logic [ERR_W-1:0] err_cnt,
  output logic             boom,
  output logic             safe
);

  localparam logic [REM_W-1:0] c_ARM_SECS = REM_W'(ARM_SECS);
  localparam logic [REM_W:0]   c_PENALTY  = (REM_W + 1)'(ERR_PENALTY);
  localparam logic [ERR_W-1:0] c_MAX_ERR  = ERR_W'(MAX_ERR);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] w_rem_nxt;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_nxt;
  logic             r_blink_en;
  logic             r_boom;
  logic             r_safe;

  logic             w_tick;
  logic [REM_W:0]   w_dec;
  logic [REM_W:0]   w_diff;
  logic [REM_W-1:0] w_rem_sat;
  logic [ERR_W-1:0] w_err_inc;

  rt_tick u_rt_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_blink_en),
    .i_rt   (blink_rt),
    .o_tick (w_tick)
  );

  // A negative 9-bit difference means the penalty overran the count
  assign w_dec     = {{REM_W{1'b0}}, w_tick} + (err ? c_PENALTY : '0);
  assign w_diff    = {1'b0, r_rem} - w_dec;
  assign w_rem_sat = w_diff[REM_W] ? '0 : w_diff[REM_W-1:0];
  assign w_err_inc = r_err + ERR_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE, ST_SAFE: begin
        if (arm) begin
          w_state_nxt = ST_ARMED;
          w_rem_nxt   = c_ARM_SECS;
          w_err_nxt   = '0;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          w_state_nxt = ST_SAFE;
        end else begin
          w_rem_nxt = w_rem_sat;
          if (err) w_err_nxt = w_err_inc;
          if ((w_rem_sat == '0) || (err && (w_err_inc == c_MAX_ERR)))
            w_state_nxt = ST_BOOM;
        end
      end
      ST_BOOM: w_state_nxt = ST_BOOM;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rem      <= '0;
      r_err      <= '0;
      r_blink_en <= 1'b0;
      r_boom     <= 1'b0;
      r_safe     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_err      <= w_err_nxt;
      r_blink_en <= (w_state_nxt == ST_ARMED);
      r_boom     <= (w_state_nxt == ST_BOOM);
      r_safe     <= (w_state_nxt == ST_SAFE);
    end
  end

  assign state     = r_state;
  assign remaining = r_rem;
  assign err_cnt   = r_err;
  assign blink_en  = r_blink_en;
  assign boom      = r_boom;
  assign safe      = r_safe;
  assign led       = r_boom | (r_blink_en & blink_rt);

endmodule

`default_nettype wire

// File: tb/tb_detonator_seq.sv
// ============================================================================
// tb_detonator_seq : two sequencer instances (ARM_SECS 3 and 200) on shared
//                    stimulus, checked against a behavioural model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_detonator_seq;

  logic clk = 1'b0;
  logic rst, arm, disarm, err, blink_rt;

  logic [1:0] s_state [2];
  logic [7:0] s_rem   [2];
  logic [3:0] s_ec    [2];
  logic       s_en    [2];
  logic       s_led   [2];
  logic       s_boom  [2];
  logic       s_safe  [2];

  int n_cmp = 0;
  int n_mis = 0;
  int ph    = 0;

  // model: 0 idle, 1 armed, 2 safe, 3 boom
  int m_st [2];
  int m_rem[2];
  int m_ec [2];
  bit m_enp[2];
  bit m_rtp;

  always #5 clk = ~clk;

  detonator_seq #(.ARM_SECS(3), .ERR_PENALTY(2), .MAX_ERR(3)) u_dut_a (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .err(err),
    .blink_rt(blink_rt), .blink_en(s_en[0]), .led(s_led[0]),
    .state(s_state[0]), .remaining(s_rem[0]), .err_cnt(s_ec[0]),
    .boom(s_boom[0]), .safe(s_safe[0])
  );

  detonator_seq #(.ARM_SECS(200), .ERR_PENALTY(2), .MAX_ERR(3)) u_dut_b (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .err(err),
    .blink_rt(blink_rt), .blink_en(s_en[1]), .led(s_led[1]),
    .state(s_state[1]), .remaining(s_rem[1]), .err_cnt(s_ec[1]),
    .boom(s_boom[1]), .safe(s_safe[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int arm_secs(input int i);
    return (i == 0) ? 3 : 200;
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit tick;
      int dec;
      tick = (m_st[i] == 1) && m_enp[i] && blink_rt && !m_rtp;
      if (rst) begin
        m_st[i] = 0; m_rem[i] = 0; m_ec[i] = 0; m_enp[i] = 1'b0;
      end else begin
        m_enp[i] = (m_st[i] == 1);
        if (m_st[i] == 0 || m_st[i] == 2) begin
          if (arm) begin
            m_st[i] = 1; m_rem[i] = arm_secs(i); m_ec[i] = 0;
          end
        end else if (m_st[i] == 1) begin
          if (disarm) begin
            m_st[i] = 2;
          end else begin
            dec = (tick ? 1 : 0) + (err ? 2 : 0);
            m_rem[i] = (m_rem[i] > dec) ? m_rem[i] - dec : 0;
            if (err) m_ec[i] = m_ec[i] + 1;
            if (m_rem[i] == 0 || (err && m_ec[i] == 3)) m_st[i] = 3;
          end
        end
      end
    end
    m_rtp = rst ? 1'b0 : blink_rt;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      string p;
      p = (i == 0) ? "A." : "B.";
      chk({p, "state"},     32'(s_state[i]), 32'(m_st[i]));
      chk({p, "remaining"}, 32'(s_rem[i]),   32'(m_rem[i]));
      chk({p, "err_cnt"},   32'(s_ec[i]),    32'(m_ec[i]));
      chk({p, "blink_en"},  32'(s_en[i]),    32'(m_st[i] == 1));
      chk({p, "boom"},      32'(s_boom[i]),  32'(m_st[i] == 3));
      chk({p, "safe"},      32'(s_safe[i]),  32'(m_st[i] == 2));
      chk({p, "led"},       32'(s_led[i]),   32'((m_st[i] == 3) || (m_st[i] == 1 && blink_rt)));
    end
  endtask

  // blink_rt is a square wave of period 8 cycles, rising when ph%8 == 4
  task automatic step(input bit a, input bit d, input bit e, input bit r);
    arm = a; disarm = d; err = e; rst = r;
    blink_rt = ph[2];
    ph++;
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask

  task automatic align(input int target);
    for (int k = 0; k < 8 && (ph % 8) != target; k++) step(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; disarm = 1'b0; err = 1'b0; blink_rt = 1'b0;
    m_rtp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_rem[i] = 0; m_ec[i] = 0; m_enp[i] = 1'b0;
    end

    repeat (3) step(0, 0, 0, 1);

    // countdown to detonation, then hold
    step(1, 0, 0, 0);
    repeat (40) step(0, 0, 0, 0);
    chk("t1.boom", 32'(s_boom[0]), 32'd1);
    chk("t1.rem",  32'(s_rem[0]),  32'd0);
    repeat (100) step(0, 0, 0, 0);
    chk("t1.hold_led", 32'(s_led[0]), 32'd1);
    chk("t1.hold_en",  32'(s_en[0]),  32'd0);

    // disarm after first tick, then re-arm
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int k = 0; k < 20 && m_rem[0] != 2; k++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("t2.state", 32'(s_state[0]), 32'd2);
    chk("t2.rem",   32'(s_rem[0]),   32'd2);
    chk("t2.led",   32'(s_led[0]),   32'd0);
    step(1, 0, 0, 0);
    chk("t2.rearm_rem", 32'(s_rem[0]), 32'd3);
    chk("t2.rearm_ec",  32'(s_ec[0]),  32'd0);

    // err coincident with the first tick: 3 - (1+2) = 0
    step(0, 0, 0, 1);
    align(0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("t4.state", 32'(s_state[0]), 32'd3);
    chk("t4.rem",   32'(s_rem[0]),   32'd0);
    chk("t4.remB",  32'(s_rem[1]),   32'd197);

    // arm while blink_rt is high, then three errors before any tick
    step(0, 0, 0, 1);
    align(4);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    chk("t5.stateB", 32'(s_state[1]), 32'd3);
    chk("t5.remB",   32'(s_rem[1]),   32'd194);
    chk("t5.ecB",    32'(s_ec[1]),    32'd3);

    // reset mid-armed
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("t6.state", 32'(s_state[1]), 32'd0);
    chk("t6.en",    32'(s_en[1]),    32'd0);
    chk("t6.led",   32'(s_led[1]),   32'd0);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0,  $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
